// File: rtl/jtvigil_pkg.sv
// Shared definitions for the Vigilante object line buffer.
package jtvigil_pkg;

  // Colour index that marks a pixel as transparent
  localparam logic [3:0] TranspIdx = 4'h0;

  typedef enum logic {
    StClear,
    StRun
  } obj_state_e;

  function automatic logic is_opaque(input logic [3:0] idx);
    return idx != TranspIdx;
  endfunction

endpackage

// File: rtl/jtvigil_linebuf_dpram.sv
// Dual-port line RAM with a registered read on each port.
// Port A has independent read and write addresses so the draw side can issue a
// read and retire a write in the same clk. When both ports write the same
// address in one clk, port A's value is kept.
module jtvigil_linebuf_dpram #(
  parameter int unsigned AW = 10,
  parameter int unsigned DW = 8
) (
  input  logic          clk,
  input  logic [AW-1:0] a_raddr,
  input  logic [AW-1:0] a_waddr,
  input  logic          a_we,
  input  logic [DW-1:0] a_din,
  output logic [DW-1:0] a_dout,
  input  logic [AW-1:0] b_addr,
  input  logic          b_we,
  input  logic [DW-1:0] b_din,
  output logic [DW-1:0] b_dout
);

  logic [DW-1:0] mem [0:(1<<AW)-1];

  // Writes (port A last so it wins a collision) and registered reads of the old data
  always_ff @(posedge clk) begin
    if (b_we) mem[b_addr] <= b_din;
    if (a_we) mem[a_waddr] <= a_din;
    a_dout <= mem[a_raddr];
    b_dout <= mem[b_addr];
  end

endmodule

// File: rtl/jtvigil_obj_linebuf.sv
// Double-buffered object line buffer: the drawer fills bank wsel while bank ~wsel
// streams to the colour mixer and is cleared behind the read. Banks swap on each
// falling LHBL. After reset the whole RAM is swept to zero.
// Build macro JTVIGIL_OBJ_FIRSTWIN_EN: two-stage read-modify-write draw path where
// the first opaque pixel at an address wins. Without it opaque pixels overwrite.
// pxl_cen must not be high in two consecutive clks (the clk after a read is used
// for the clear-after-read write on port B).
module jtvigil_obj_linebuf
  import jtvigil_pkg::*;
#(
  parameter int unsigned AW = 9,
  parameter int unsigned DW = 8
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          pxl_cen,
  input  logic          flip,
  input  logic          LHBL,
  input  logic [8:0]    h,
  input  logic          wr_en,
  input  logic [AW-1:0] wr_addr,
  input  logic [DW-1:0] wr_pxl,
  output logic          line_start,
  output logic          busy,
  output logic [DW-1:0] pxl
);

  localparam int unsigned RAW = AW + 1;

  obj_state_e     state_q, state_d;
  logic [RAW-1:0] clr_cnt_q;
  logic           run, wsel_q, lhbl_q, swap;

  logic [RAW-1:0] a_raddr, a_waddr, b_addr;
  logic           a_we, b_we;
  logic [DW-1:0]  a_din, a_dout, b_dout;

  logic [RAW-1:0] pipe_waddr, pipe_raddr;
  logic           pipe_we;
  logic [DW-1:0]  pipe_din;

  logic [RAW-1:0] rd_addr_now, rd_addr_q;
  logic           clr_pend_q, rd_live_q;
  logic [DW-1:0]  rd_data_q;

  // State register and clear-sweep counter
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= StClear;
      clr_cnt_q <= '0;
    end else begin
      state_q <= state_d;
      if (state_q == StClear) clr_cnt_q <= clr_cnt_q + 1'b1;
    end
  end

  // Next state: leave the sweep after the last address has been written
  always_comb begin
    state_d = state_q;
    busy    = 1'b0;
    unique case (state_q)
      StClear: begin
        busy = 1'b1;
        if (&clr_cnt_q) state_d = StRun;
      end
      StRun: state_d = StRun;
    endcase
  end

  assign run  = (state_q == StRun);
  assign swap = run & lhbl_q & ~LHBL;

  // Bank select and line_start pulse on the registered LHBL falling edge
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      lhbl_q     <= 1'b0;
      line_start <= 1'b0;
      wsel_q     <= 1'b0;
    end else begin
      lhbl_q     <= LHBL;
      line_start <= swap;
      if (swap) wsel_q <= ~wsel_q;
    end
  end

  assign pipe_raddr = {wsel_q, wr_addr};

`ifdef JTVIGIL_OBJ_FIRSTWIN_EN
  logic          s_valid_q, s_bank_q, fwd_q;
  logic [AW-1:0] s_addr_q;
  logic [DW-1:0] s_pxl_q, fwd_pxl_q, stored, s_result;
  logic          accept, hit, s_write;

  // Stage 2: compare against the stored pixel (or the forwarded previous result)
  always_comb begin
    accept   = wr_en & run;
    hit      = s_valid_q && (s_addr_q == wr_addr) && (s_bank_q == wsel_q);
    stored   = fwd_q ? fwd_pxl_q : a_dout;
    s_write  = s_valid_q && is_opaque(s_pxl_q[3:0]) && !is_opaque(stored[3:0]);
    s_result = s_write ? s_pxl_q : stored;
    pipe_we    = s_write;
    pipe_waddr = {s_bank_q, s_addr_q};
    pipe_din   = s_pxl_q;
  end

  // Stage 1: latch the request; the bank is frozen here so it survives a swap
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s_valid_q <= 1'b0;
      s_bank_q  <= 1'b0;
      s_addr_q  <= '0;
      s_pxl_q   <= '0;
      fwd_q     <= 1'b0;
      fwd_pxl_q <= '0;
    end else begin
      s_valid_q <= accept;
      if (accept) begin
        s_bank_q <= wsel_q;
        s_addr_q <= wr_addr;
        s_pxl_q  <= wr_pxl;
      end
      // RAM read at this edge misses the stage-2 write, so carry its result over
      fwd_q     <= accept & hit;
      fwd_pxl_q <= s_result;
    end
  end
`else
  logic unused_a_dout;
  assign unused_a_dout = ^a_dout;

  // Single-stage draw path: opaque pixels overwrite, transparent ones are dropped
  always_comb begin
    pipe_we    = wr_en & run & is_opaque(wr_pxl[3:0]);
    pipe_waddr = {wsel_q, wr_addr};
    pipe_din   = wr_pxl;
  end
`endif

  // Port A: clear sweep takes over the write port while busy
  always_comb begin
    a_raddr = pipe_raddr;
    a_we    = pipe_we;
    a_waddr = pipe_waddr;
    a_din   = pipe_din;
    if (busy) begin
      a_we    = 1'b1;
      a_waddr = clr_cnt_q;
      a_din   = '0;
    end
  end

  assign rd_addr_now = {~wsel_q, flip ? ~h[AW-1:0] : h[AW-1:0]};

  // Port B: read on pxl_cen, then zero the same address on the following clk
  always_comb begin
    b_we   = clr_pend_q;
    b_addr = clr_pend_q ? rd_addr_q : rd_addr_now;
  end

  // Display side: capture the read, present it on the next pxl_cen
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      clr_pend_q <= 1'b0;
      rd_addr_q  <= '0;
      rd_live_q  <= 1'b0;
      rd_data_q  <= '0;
      pxl        <= '0;
    end else begin
      clr_pend_q <= pxl_cen;
      if (pxl_cen) begin
        rd_addr_q <= rd_addr_now;
        rd_live_q <= run;
        pxl       <= (LHBL && run) ? rd_data_q : '0;
      end
      // Reads issued during the sweep may see stale data; drop them
      if (clr_pend_q) rd_data_q <= rd_live_q ? b_dout : '0;
    end
  end

  jtvigil_linebuf_dpram #(
    .AW (RAW),
    .DW (DW)
  ) u_ram (
    .clk     (clk),
    .a_raddr (a_raddr),
    .a_waddr (a_waddr),
    .a_we    (a_we),
    .a_din   (a_din),
    .a_dout  (a_dout),
    .b_addr  (b_addr),
    .b_we    (b_we),
    .b_din   ('0),
    .b_dout  (b_dout)
  );

endmodule

// File: tb/tb_jtvigil_obj_linebuf.sv
// Self-checking bench for jtvigil_obj_linebuf (honours JTVIGIL_OBJ_FIRSTWIN_EN).
module tb_jtvigil_obj_linebuf;

  localparam int AW = 9;
  localparam int DW = 8;

`ifdef JTVIGIL_OBJ_FIRSTWIN_EN
  localparam logic [7:0] Exp20 = 8'h21;
`else
  localparam logic [7:0] Exp20 = 8'h47;
`endif

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          pxl_cen = 1'b0;
  logic          flip = 1'b0;
  logic          LHBL = 1'b1;
  logic [8:0]    h = '0;
  logic          wr_en = 1'b0;
  logic [AW-1:0] wr_addr = '0;
  logic [DW-1:0] wr_pxl = '0;
  logic          line_start, busy;
  logic [DW-1:0] pxl;

  int n_checks = 0;
  int n_fail = 0;
  bit chk_on = 1'b0;

  always #10 clk = ~clk;

  jtvigil_obj_linebuf #(
    .AW (AW),
    .DW (DW)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .pxl_cen    (pxl_cen),
    .flip       (flip),
    .LHBL       (LHBL),
    .h          (h),
    .wr_en      (wr_en),
    .wr_addr    (wr_addr),
    .wr_pxl     (wr_pxl),
    .line_start (line_start),
    .busy       (busy),
    .pxl        (pxl)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model: two line memories as one flat array ----
  logic [7:0] m [0:1023];
  int         sweep;
  bit         run_m, wsel_m, lhbl_prev, ls_m, clr_v, pend_v;
  logic [7:0] pxl_m, last_val, rv, pend_p;
  logic [9:0] ra, clr_a, pend_a;

  task automatic model_step();
    if (!rst_n) begin
      foreach (m[i]) m[i] = 8'h00;
      sweep = 0; run_m = 0; wsel_m = 0; lhbl_prev = 0; ls_m = 0;
      pxl_m = 0; last_val = 0; clr_v = 0; pend_v = 0;
    end else begin
      // display read sees memory before this edge's writes
      if (pxl_cen) begin
        ra = {~wsel_m, flip ? ~h : h};
        rv = run_m ? m[ra] : 8'h00;
      end
      if (clr_v) m[clr_a] = 8'h00;
      clr_v = pxl_cen;
      clr_a = ra;
`ifdef JTVIGIL_OBJ_FIRSTWIN_EN
      if (pend_v && pend_p[3:0] != 0 && m[pend_a][3:0] == 0) m[pend_a] = pend_p;
      pend_v = run_m && wr_en;
      pend_a = {wsel_m, wr_addr};
      pend_p = wr_pxl;
`else
      if (run_m && wr_en && wr_pxl[3:0] != 0) m[{wsel_m, wr_addr}] = wr_pxl;
`endif
      if (pxl_cen) begin
        pxl_m    = (LHBL && run_m) ? last_val : 8'h00;
        last_val = rv;
      end
      ls_m = run_m && lhbl_prev && !LHBL;
      if (ls_m) wsel_m = ~wsel_m;
      lhbl_prev = LHBL;
      if (!run_m) begin
        if (sweep == 1023) run_m = 1;
        sweep++;
      end
    end
  endtask

  always @(posedge clk) model_step();

  // Per-cycle comparison against the model
  always @(negedge clk) begin
    if (chk_on) begin
      check("pxl", pxl, pxl_m);
      check("busy", busy, !run_m);
      check("line_start", line_start, ls_m);
    end
  end

  // ---------------- stimulus helpers ----------------
  logic [7:0] line_buf [0:511];

  task automatic wr(input logic [8:0] a, input logic [7:0] p);
    wr_en = 1'b1; wr_addr = a; wr_pxl = p;
    @(negedge clk);
    wr_en = 1'b0;
  endtask

  // One active line, h 0..511, pxl_cen every other clk; line_buf[h] holds the
  // pixel that came out for that h
  task automatic do_line(input bit f);
    flip = f;
    LHBL = 1'b1;
    for (int i = 0; i < 512; i++) begin
      h = i[8:0];
      pxl_cen = 1'b1;
      @(negedge clk);
      pxl_cen = 1'b0;
      if (i > 0) line_buf[i-1] = pxl;
      @(negedge clk);
    end
  endtask

  // Blank period; optionally a write in the clk just before LHBL falls
  task automatic do_blank(input bit edge_wr, input logic [8:0] ea, input logic [7:0] ep,
                          output int pulses);
    pulses = 0;
    if (edge_wr) wr(ea, ep);
    LHBL = 1'b0;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      if (line_start) pulses++;
    end
  endtask

  function automatic int count_nz();
    int n = 0;
    for (int i = 0; i < 511; i++) if (line_buf[i] != 8'h00) n++;
    return n;
  endfunction

  // Count clks with busy high; an LHBL dip mid-sweep must be ignored
  task automatic wait_clear(input string name);
    int cnt = 0;
    while (busy && cnt < 2000) begin
      LHBL = !(cnt >= 100 && cnt < 110);
      cnt++;
      @(negedge clk);
    end
    LHBL = 1'b1;
    check(name, cnt, 1024);
  endtask

  task automatic reset_checks(input string tag);
    check({tag, "_busy"}, busy, 1'b1);
    check({tag, "_pxl"}, pxl, 8'h00);
    check({tag, "_ls"}, line_start, 1'b0);
  endtask

  initial begin
    repeat (60000) @(posedge clk);
    $display("FAIL watchdog: run did not end, got timeout, expected finish");
    $fatal(1);
  end

  initial begin
    int p;
    repeat (3) @(negedge clk);
    reset_checks("rst");
    rst_n  = 1'b1;
    chk_on = 1'b1;
    wait_clear("busy_len");

    // Both banks read back as zero after the sweep
    do_blank(0, 0, 0, p); check("ls_pulse0", p, 1);
    do_line(0);           check("bank0_zero", count_nz(), 0);
    do_blank(0, 0, 0, p); check("ls_pulse1", p, 1);
    do_line(0);           check("bank1_zero", count_nz(), 0);

    // Draw into the back bank, show it one line later
    do_blank(0, 0, 0, p); check("ls_pulse2", p, 1);
    wr(9'd10, 8'h35);
    wr(9'd20, 8'h21);
    wr(9'd20, 8'h47);
    wr(9'd30, 8'h12);
    wr(9'd31, 8'h00);
    wr(9'd30, 8'h50);
    do_line(0);
    do_blank(0, 0, 0, p); check("ls_pulse3", p, 1);
    do_line(0);
    check("px10", line_buf[10], 8'h35);
    check("px11", line_buf[11], 8'h00);
    check("px20_prio", line_buf[20], Exp20);
    check("px30_transp", line_buf[30], 8'h12);
    check("px31", line_buf[31], 8'h00);
    check("round1_nz", count_nz(), 3);

    // Same bank again two swaps later: cleared behind the read
    do_blank(0, 0, 0, p); do_line(0);
    do_blank(0, 0, 0, p); do_line(0);
    check("px10_cleared", line_buf[10], 8'h00);
    check("cleared_nz", count_nz(), 0);

    // Flipped readout
    do_blank(0, 0, 0, p);
    wr(9'd5, 8'h33);
    do_line(0);
    do_blank(0, 0, 0, p);
    do_line(1);
    check("flip_1fa", line_buf[9'h1FA], 8'h33);
    check("flip_h5", line_buf[5], 8'h00);

    // Write in the clk before LHBL falls: lands in the bank shown next
    do_blank(1, 9'd40, 8'h66, p); check("ls_single", p, 1);
    do_line(0);
    check("edge_px40", line_buf[40], 8'h66);
    check("edge_nz", count_nz(), 1);

    // Reset mid-run: sweep restarts and the pending drawing is gone
    do_blank(0, 0, 0, p);
    wr(9'd50, 8'h77);
    #1;
    chk_on = 1'b0;
    rst_n  = 1'b0;
    repeat (3) @(negedge clk);
    reset_checks("rst2");
    rst_n  = 1'b1;
    chk_on = 1'b1;
    wait_clear("busy_len2");
    do_blank(0, 0, 0, p); check("ls_pulse_r", p, 1);
    do_line(0);           check("rst_bank_a", count_nz(), 0);
    do_blank(0, 0, 0, p);
    do_line(0);           check("rst_bank_b", count_nz(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
